simd_host_loader: RTL and testbench

SIMD_HOST_LOADER -- requirements
Module: simd_host_loader

---
 rtl/simd_pkg.sv | 26 ++
 rtl/simd_host_loader.sv | 189 ++++++++++++++++++
 tb/tb_simd_host_loader.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/simd_pkg.sv
// Shared types for the SIMD host loader: command opcodes and controller states.
package simd_pkg;

  typedef enum logic [2:0] {
    OpLoadA   = 3'd0,
    OpLoadB   = 3'd1,
    OpLoadIns = 3'd2,
    OpReadR   = 3'd3,
    OpRun     = 3'd4
  } cmd_op_e;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StLoad    = 3'd1,
    StRdIssue = 3'd2,
    StRdWait  = 3'd3,
    StRdOut   = 3'd4,
    StRun     = 3'd5
  } state_e;

  // Opcodes 5..7 are reserved and flagged as errors.
  function automatic logic is_legal_op(input logic [2:0] op);
    return (op <= 3'(OpRun));
  endfunction

endpackage

// File: rtl/simd_host_loader.sv
// Host-side command engine: streams words into the A/B/INS banks, reads the
// result bank back onto a valid/ready stream, and launches datapath runs.
module simd_host_loader
  import simd_pkg::*;
#(
  parameter int unsigned PE_COUNT    = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BRAM_DEPTH  = 1024,
  parameter int unsigned INS_WIDTH   = 64,
  parameter int unsigned RUN_TIMEOUT = 4096,
  localparam int unsigned AW = $clog2(BRAM_DEPTH),
  localparam int unsigned DW = PE_COUNT * DATA_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [AW-1:0]     cmd_base,
  input  logic [AW:0]       cmd_len,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DW-1:0]     s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DW-1:0]     m_data,
  output logic              bram_a_wr_en,
  output logic [AW-1:0]     bram_a_wr_addr,
  output logic [DW-1:0]     bram_a_wr_data,
  output logic              bram_b_wr_en,
  output logic [AW-1:0]     bram_b_wr_addr,
  output logic [DW-1:0]     bram_b_wr_data,
  output logic              bram_ins_wr_en,
  output logic [AW-1:0]     bram_ins_wr_addr,
  output logic [INS_WIDTH-1:0] bram_ins_wr_data,
  output logic [AW-1:0]     bram_r_r_addr,
  input  logic [DW-1:0]     bram_r_r_data,
  output logic              core_start,
  input  logic              core_done,
  output logic              busy,
  output logic              cmd_done,
  output logic              err
);

  localparam int unsigned TW = $clog2(RUN_TIMEOUT + 1);

  state_e          r_state, w_state_d;
  logic [2:0]      r_op;
  logic [AW:0]     r_len, r_off;
  logic [AW-1:0]   r_ptr, w_ptr_nxt;
  logic            r_a_wr_en, r_b_wr_en, r_ins_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data, r_m_data;
  logic            r_core_start, r_cmd_done, r_err;
  logic [TW-1:0]   r_tmo;

  logic w_accept, w_legal, w_noop, w_beat, w_last, w_rd_hs, w_run_done, w_run_tmo;

  // Handshake decode and per-state completion conditions.
  always_comb begin
    w_accept   = cmd_valid && (r_state == StIdle);
    w_legal    = is_legal_op(cmd_op);
    w_noop     = w_accept && (!w_legal || (cmd_len == '0));
    w_beat     = (r_state == StLoad) && s_valid;
    w_last     = (r_off == (r_len - {{AW{1'b0}}, 1'b1}));
    w_rd_hs    = (r_state == StRdOut) && m_ready;
    // A core_done level left over from a previous run is ignored in the start cycle.
    w_run_done = (r_state == StRun) && !r_core_start && core_done;
    w_run_tmo  = (r_state == StRun) && !w_run_done && (r_tmo == TW'(RUN_TIMEOUT - 1));
    w_ptr_nxt  = (r_ptr == AW'(BRAM_DEPTH - 1)) ? '0 : r_ptr + 1'b1;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_d = r_state;
    cmd_ready = (r_state == StIdle);
    busy      = (r_state != StIdle);
    s_ready   = (r_state == StLoad);
    m_valid   = (r_state == StRdOut);
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_noop) begin
          case (cmd_op)
            OpLoadA, OpLoadB, OpLoadIns: w_state_d = StLoad;
            OpReadR:                     w_state_d = StRdIssue;
            OpRun:                       w_state_d = StRun;
            default:                     w_state_d = StIdle;
          endcase
        end
      end
      StLoad:    if (w_beat && w_last) w_state_d = StIdle;
      StRdIssue: w_state_d = StRdWait;
      StRdWait:  w_state_d = StRdOut;
      StRdOut:   if (w_rd_hs) w_state_d = w_last ? StIdle : StRdIssue;
      StRun:     if (w_run_done || w_run_tmo) w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_d;
  end

  // Command context, write port, readback capture, run timer and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op         <= '0;
      r_len        <= '0;
      r_off        <= '0;
      r_ptr        <= '0;
      r_a_wr_en    <= 1'b0;
      r_b_wr_en    <= 1'b0;
      r_ins_wr_en  <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_m_data     <= '0;
      r_core_start <= 1'b0;
      r_cmd_done   <= 1'b0;
      r_err        <= 1'b0;
      r_tmo        <= '0;
    end else begin
      r_a_wr_en    <= 1'b0;
      r_b_wr_en    <= 1'b0;
      r_ins_wr_en  <= 1'b0;
      r_core_start <= 1'b0;
      r_cmd_done   <= 1'b0;

      if (w_accept) begin
        r_op         <= cmd_op;
        r_len        <= cmd_len;
        r_off        <= '0;
        r_ptr        <= cmd_base;
        r_tmo        <= '0;
        r_err        <= !w_legal;
        r_cmd_done   <= w_noop;
        r_core_start <= (cmd_op == OpRun) && !w_noop;
      end

      if (w_beat) begin
        r_a_wr_en   <= (r_op == OpLoadA);
        r_b_wr_en   <= (r_op == OpLoadB);
        r_ins_wr_en <= (r_op == OpLoadIns);
        r_wr_addr   <= r_ptr;
        r_wr_data   <= s_data;
        r_off       <= r_off + 1'b1;
        r_ptr       <= w_ptr_nxt;
        r_cmd_done  <= w_last;
      end

      if (r_state == StRdWait) r_m_data <= bram_r_r_data;

      if (w_rd_hs) begin
        r_off      <= r_off + 1'b1;
        r_ptr      <= w_ptr_nxt;
        r_cmd_done <= w_last;
      end

      if (r_state == StRun) begin
        r_tmo <= r_tmo + 1'b1;
        if (w_run_done) r_cmd_done <= 1'b1;
        if (w_run_tmo) begin
          r_cmd_done <= 1'b1;
          r_err      <= 1'b1;
        end
      end
    end
  end

  // One write register set is shared; the per-bank enables select the target.
  always_comb begin
    bram_a_wr_en     = r_a_wr_en;
    bram_a_wr_addr   = r_wr_addr;
    bram_a_wr_data   = r_wr_data;
    bram_b_wr_en     = r_b_wr_en;
    bram_b_wr_addr   = r_wr_addr;
    bram_b_wr_data   = r_wr_data;
    bram_ins_wr_en   = r_ins_wr_en;
    bram_ins_wr_addr = r_wr_addr;
    bram_ins_wr_data = r_wr_data[INS_WIDTH-1:0];
    bram_r_r_addr    = r_ptr;
    m_data           = r_m_data;
    core_start       = r_core_start;
    cmd_done         = r_cmd_done;
    err              = r_err;
  end

endmodule

// File: tb/tb_simd_host_loader.sv
// Directed bench for simd_host_loader with a transaction scoreboard.
module tb_simd_host_loader;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid, cmd_valid2, cmd_ready, cmd_ready2;
  logic [2:0]   cmd_op;
  logic [9:0]   cmd_base;
  logic [10:0]  cmd_len;
  logic         s_valid, s_ready, m_valid, m_ready;
  logic [127:0] s_data, m_data;
  logic         a_en, b_en, ins_en;
  logic [9:0]   a_addr, b_addr, ins_addr, r_addr;
  logic [127:0] a_data, b_data, r_data;
  logic [63:0]  ins_data;
  logic         core_start, core_done, busy, cmd_done, err;
  // Second instance (RUN_TIMEOUT=16) used only for the timeout case.
  logic         core_done2, core_start2, busy2, cmd_done2, err2;
  logic         u2_s_ready, u2_m_valid, u2_a_en, u2_b_en, u2_ins_en;
  logic [127:0] u2_m_data, u2_a_data, u2_b_data;
  logic [63:0]  u2_ins_data;
  logic [9:0]   u2_a_addr, u2_b_addr, u2_ins_addr, u2_r_addr;

  always #5 clk = ~clk;

  simd_host_loader u_dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .bram_a_wr_en(a_en), .bram_a_wr_addr(a_addr), .bram_a_wr_data(a_data),
    .bram_b_wr_en(b_en), .bram_b_wr_addr(b_addr), .bram_b_wr_data(b_data),
    .bram_ins_wr_en(ins_en), .bram_ins_wr_addr(ins_addr), .bram_ins_wr_data(ins_data),
    .bram_r_r_addr(r_addr), .bram_r_r_data(r_data), .core_start(core_start),
    .core_done(core_done), .busy(busy), .cmd_done(cmd_done), .err(err)
  );

  simd_host_loader #(.RUN_TIMEOUT(16)) u_dut_to (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op),
    .cmd_base(cmd_base), .cmd_len(cmd_len), .s_valid(1'b0), .s_ready(u2_s_ready),
    .s_data(s_data), .m_valid(u2_m_valid), .m_ready(m_ready), .m_data(u2_m_data),
    .bram_a_wr_en(u2_a_en), .bram_a_wr_addr(u2_a_addr), .bram_a_wr_data(u2_a_data),
    .bram_b_wr_en(u2_b_en), .bram_b_wr_addr(u2_b_addr), .bram_b_wr_data(u2_b_data),
    .bram_ins_wr_en(u2_ins_en), .bram_ins_wr_addr(u2_ins_addr),
    .bram_ins_wr_data(u2_ins_data), .bram_r_r_addr(u2_r_addr), .bram_r_r_data(r_data),
    .core_start(core_start2), .core_done(core_done2), .busy(busy2), .cmd_done(cmd_done2),
    .err(err2)
  );

  // Result bank: synchronous read, data one cycle after the address.
  function automatic logic [127:0] r_word(input logic [9:0] a);
    logic [31:0] a32;
    a32 = {22'b0, a};
    return {32'h3000_0000 + a32, 32'h2000_0000 + a32, 32'h1000_0000 + a32, 32'hF000_0000 + a32};
  endfunction
  always @(posedge clk) r_data <= r_word(r_addr);

  typedef struct { int bank; logic [9:0] addr; logic [127:0] data; } wr_t;
  typedef struct { logic err; logic with_wr; } done_t;
  wr_t          wq[$];
  logic [127:0] rq[$];
  done_t        dq[$];

  int n_checks = 0, n_errors = 0;
  int n_start = 0, n_start2 = 0;
  bit chk_en = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask
  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chki(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-cycle scoreboard: every write, readback handshake and cmd_done is matched
  // against the queues filled by the directed tests.
  int           nwr, wbank;
  logic [9:0]   waddr;
  logic [127:0] wdata, prev_md;
  logic         prev_mv = 1'b0, prev_mr = 1'b0;
  wr_t          we;
  done_t        de;
  always @(negedge clk) begin
    if (chk_en) begin
      nwr = int'(a_en) + int'(b_en) + int'(ins_en);
      chk1("ready_is_not_busy", cmd_ready, !busy);
      chk1("at_most_one_wr_en", nwr <= 1, 1'b1);
      if (nwr == 1) begin
        if (a_en) begin wbank = 0; waddr = a_addr; wdata = a_data; end
        else if (b_en) begin wbank = 1; waddr = b_addr; wdata = b_data; end
        else begin wbank = 2; waddr = ins_addr; wdata = {64'h0, ins_data}; end
        chk1("write_expected", wq.size() != 0, 1'b1);
        if (wq.size() != 0) begin
          we = wq.pop_front();
          chki("wr_bank", wbank, we.bank);
          chkw("wr_addr", 128'(waddr), 128'(we.addr));
          chkw("wr_data", wdata, we.data);
        end
      end
      if (m_valid && prev_mv && !prev_mr) chkw("m_data_stable", m_data, prev_md);
      if (m_valid && m_ready) begin
        chk1("read_expected", rq.size() != 0, 1'b1);
        if (rq.size() != 0) chkw("m_data", m_data, rq.pop_front());
      end
      if (cmd_done) begin
        chk1("cmd_done_expected", dq.size() != 0, 1'b1);
        if (dq.size() != 0) begin
          de = dq.pop_front();
          chk1("err_at_done", err, de.err);
          chk1("done_with_final_wr", nwr == 1, de.with_wr);
        end
      end
      if (core_start) n_start++;
      if (core_start2) n_start2++;
    end
    prev_mv = m_valid;
    prev_mr = m_ready;
    prev_md = m_data;
  end

  task automatic issue(input logic [2:0] op, input logic [9:0] base, input logic [10:0] len,
                       input bit second = 0);
    int k;
    cmd_op = op; cmd_base = base; cmd_len = len;
    if (second) cmd_valid2 = 1'b1; else cmd_valid = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (second ? cmd_ready2 : cmd_ready) break;
    end
    chk1("cmd_accepted_in_time", k < 100, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_valid2 = 1'b0;
  endtask

  task automatic beat(input logic [127:0] d, input int gap);
    int k;
    s_valid = 1'b1; s_data = d;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (s_ready) break;
    end
    chk1("beat_accepted_in_time", k < 100, 1'b1);
    @(posedge clk); #1;
    s_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic wait_done(input string name);
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (cmd_done) break;
    end
    chk1(name, k < 100, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic wait_mvalid();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (m_valid) break;
    end
    chk1("m_valid_in_time", k < 100, 1'b1);
  endtask

  task automatic push_wr(input int bank, input logic [9:0] addr, input logic [127:0] data);
    wr_t e;
    e.bank = bank; e.addr = addr; e.data = data;
    wq.push_back(e);
  endtask
  task automatic push_done(input logic e, input logic w);
    done_t d;
    d.err = e; d.with_wr = w;
    dq.push_back(d);
  endtask

  initial begin
    int k, s0;
    rst = 1'b1; cmd_valid = 0; cmd_valid2 = 0; cmd_op = 0; cmd_base = 0; cmd_len = 0;
    s_valid = 0; s_data = 0; m_ready = 1'b1; core_done = 0; core_done2 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_cmd_ready", cmd_ready, 1'b1);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_cmd_done", cmd_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_s_ready", s_ready, 1'b0);
    chk1("rst_m_valid", m_valid, 1'b0);
    chk1("rst_wr_en", a_en | b_en | ins_en, 1'b0);
    chk1("rst_core_start", core_start, 1'b0);
    chkw("rst_addrs", {a_addr, ins_addr, r_addr}, '0);
    chkw("rst_m_data", m_data, '0);
    chk_en = 1;
    @(posedge clk); #1 rst = 1'b0;

    // LOAD_A wrapping past the top of the bank.
    push_wr(0, 10'd1022, 128'h1); push_wr(0, 10'd1023, 128'h2);
    push_wr(0, 10'd0, 128'h3);    push_wr(0, 10'd1, 128'h4);
    push_done(1'b0, 1'b1);
    issue(3'd0, 10'd1022, 11'd4);
    for (int i = 1; i <= 4; i++) beat(128'(i), 0);
    wait_done("load_a_done");
    chki("load_a_writes_left", wq.size(), 0);

    // LOAD_INS with gaps: only the low 64 bits reach the instruction bank.
    push_wr(2, 10'd5, 128'h0000_0000_0000_0000_1111_2222_3333_4444);
    push_wr(2, 10'd6, 128'h0000_0000_0000_0000_5555_6666_7777_8888);
    push_done(1'b0, 1'b1);
    issue(3'd2, 10'd5, 11'd2);
    beat(128'hAAAA_BBBB_CCCC_DDDD_1111_2222_3333_4444, 2);
    beat(128'hEEEE_FFFF_0123_4567_5555_6666_7777_8888, 0);
    wait_done("load_ins_done");
    repeat (3) @(posedge clk);
    #1 chki("load_ins_writes_left", wq.size(), 0);

    // READ_R with a 5-cycle stall on the second word.
    rq.push_back(128'h3000000A_2000000A_1000000A_F000000A);
    rq.push_back(128'h3000000B_2000000B_1000000B_F000000B);
    rq.push_back(128'h3000000C_2000000C_1000000C_F000000C);
    push_done(1'b0, 1'b0);
    m_ready = 1'b1;
    issue(3'd3, 10'd10, 11'd3);
    wait_mvalid();
    @(posedge clk); #1 m_ready = 1'b0;
    wait_mvalid();
    repeat (5) @(posedge clk);
    #1 m_ready = 1'b1;
    @(posedge clk); #1;
    wait_mvalid();
    wait_done("read_done");
    chki("read_words_left", rq.size(), 0);
    chk1("read_m_valid_low", m_valid, 1'b0);

    // Illegal opcode, then a legal zero-length command clears err.
    push_done(1'b1, 1'b0);
    issue(3'd7, 10'd0, 11'd1);
    @(negedge clk);
    chk1("illegal_done_next_cycle", cmd_done, 1'b1);
    chk1("illegal_err", err, 1'b1);
    @(posedge clk); #1;
    push_done(1'b0, 1'b0);
    issue(3'd1, 10'd0, 11'd0);
    @(negedge clk);
    chk1("len0_done_next_cycle", cmd_done, 1'b1);
    chk1("err_cleared_by_legal", err, 1'b0);
    @(posedge clk); #1;

    // RUN completed by core_done 20 cycles after core_start.
    s0 = n_start;
    push_done(1'b0, 1'b0);
    issue(3'd4, 10'd0, 11'd1);
    @(negedge clk);
    chk1("core_start_on_entry", core_start, 1'b1);
    repeat (20) @(posedge clk);
    #1 core_done = 1'b1;
    @(posedge clk); #1 core_done = 1'b0;
    wait_done("run_done");
    chki("run_core_start_pulses", n_start - s0, 1);
    chk1("run_err", err, 1'b0);

    // RUN with no core_done on the RUN_TIMEOUT=16 instance.
    issue(3'd4, 10'd0, 11'd1, 1);
    for (k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (cmd_done2) break;
    end
    chki("timeout_done_cycle", k, 17);
    chk1("timeout_err", err2, 1'b1);
    chki("timeout_core_start_pulses", n_start2, 1);
    chk1("timeout_back_idle", cmd_ready2, 1'b1);
    @(posedge clk); #1;

    // Reset during a LOAD_A of 8 words after 3 beats.
    push_wr(0, 10'd100, 128'h100); push_wr(0, 10'd101, 128'h101);
    push_wr(0, 10'd102, 128'h102);
    issue(3'd0, 10'd100, 11'd8);
    beat(128'h100, 0); beat(128'h101, 0); beat(128'h102, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("abort_cmd_ready", cmd_ready, 1'b1);
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_s_ready", s_ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    chki("abort_writes_kept", wq.size(), 0);

    chki("done_events_left", dq.size(), 0);
    chki("total_core_starts", n_start, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
